// File: rtl/probe_capture_buffer.sv
// Triggered capture buffer for the motor-control probe bus: circular pre-trigger
// history, post-trigger fill, then a streamed readout of DEPTH samples.
//
// state | meaning
// IDLE  | no capture; waiting for arm
// FILL  | collecting the pre-trigger window, trigger not evaluated
// WAIT  | writing circularly, evaluating the trigger
// POST  | writing the post-trigger samples
// DONE  | capture complete, waiting for rd_en or re-arm
// READ  | streaming DEPTH samples out from start_ptr
module probe_capture_buffer #(
  parameter int DATA_W = 67,
  parameter int ADDR_W = 10,
  localparam int DEPTH = 2**ADDR_W
) (
  input  logic              controlCLK,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] probe_i,
  input  logic              sample_en,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        trig_mode,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [ADDR_W-1:0] pre_count,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              triggered,
  output logic              done,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4,
    S_READ = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] PRE_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, start_ptr;
  logic [ADDR_W-1:0] pre_eff, fill_rem, post_rem, rd_rem;
  logic [1:0]        t_mode;
  logic [DATA_W-1:0] t_mask, t_value, prev;
  logic              prev_valid;
  logic              rd_valid_q, rd_last_q, triggered_q, done_q;

  logic [ADDR_W-1:0] pre_clip, rd_addr;
  logic              qual_wr, do_arm, rd_issue;
  logic              match_s, match_p, change_s, fire;

  always_comb begin
    pre_clip = (pre_count > PRE_MAX) ? PRE_MAX : pre_count;
    qual_wr  = sample_en && !abort &&
               (state == S_FILL || state == S_WAIT || state == S_POST);
    do_arm   = arm && !abort && (state == S_IDLE || state == S_DONE);
    rd_issue = rd_en && !abort &&
               ((state == S_DONE && !arm) || (state == S_READ && rd_rem != '0));
    rd_addr  = (state == S_DONE) ? start_ptr : rd_ptr;
    match_s  = ((probe_i ^ t_value) & t_mask) == '0;
    match_p  = ((prev ^ t_value) & t_mask) == '0;
    change_s = ((probe_i ^ prev) & t_mask) != '0;
    fire     = 1'b0;
    case (t_mode)
      2'b00:   fire = match_s;
      2'b01:   fire = prev_valid && change_s;
      2'b10:   fire = prev_valid && match_s && !match_p;
      default: fire = 1'b1;
    endcase
  end

  // Plain dual-port array with registered read so it maps onto block RAM.
  always_ff @(posedge controlCLK) begin
    if (qual_wr) mem[wr_ptr] <= probe_i;
    if (rd_issue) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge controlCLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      start_ptr   <= '0;
      pre_eff     <= '0;
      fill_rem    <= '0;
      post_rem    <= '0;
      rd_rem      <= '0;
      t_mode      <= '0;
      t_mask      <= '0;
      t_value     <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_issue;
      rd_last_q  <= rd_issue && (state == S_READ) && (rd_rem == ONE);
      if (qual_wr) begin
        wr_ptr     <= wr_ptr + ONE;
        prev       <= probe_i;
        prev_valid <= 1'b1;
      end
      if (abort) begin
        state       <= S_IDLE;
        done_q      <= 1'b0;
        triggered_q <= 1'b0;
      end else if (do_arm) begin
        state       <= (pre_clip == '0) ? S_WAIT : S_FILL;
        wr_ptr      <= '0;
        triggered_q <= 1'b0;
        done_q      <= 1'b0;
        pre_eff     <= pre_clip;
        fill_rem    <= pre_clip;
        t_mode      <= trig_mode;
        t_mask      <= trig_mask;
        t_value     <= trig_value;
        prev_valid  <= 1'b0;
      end else begin
        case (state)
          S_FILL: if (qual_wr) begin
            fill_rem <= fill_rem - ONE;
            if (fill_rem == ONE) state <= S_WAIT;
          end
          S_WAIT: if (qual_wr && fire) begin
            triggered_q <= 1'b1;
            start_ptr   <= wr_ptr - pre_eff;
            post_rem    <= PRE_MAX - pre_eff;
            if (pre_eff == PRE_MAX) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state <= S_POST;
            end
          end
          S_POST: if (qual_wr) begin
            post_rem <= post_rem - ONE;
            if (post_rem == ONE) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
          S_DONE: if (rd_issue) begin
            state  <= S_READ;
            rd_ptr <= start_ptr + ONE;
            rd_rem <= PRE_MAX;
          end
          S_READ: begin
            // rd_last is on the bus this cycle, so the capture is fully drained.
            if (rd_last_q) begin
              state       <= S_IDLE;
              done_q      <= 1'b0;
              triggered_q <= 1'b0;
            end else if (rd_issue) begin
              rd_ptr <= rd_ptr + ONE;
              rd_rem <= rd_rem - ONE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_data   = rd_valid_q ? ram_q : '0;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign state_o   = state;

endmodule

// File: tb/tb_probe_capture_buffer.sv
// Bench for probe_capture_buffer at DATA_W=8, DEPTH=16: per-scenario tasks, readout
// checked against a queue of expected samples built from the driven history.
module tb_probe_capture_buffer;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEP = 16;

  logic          controlCLK = 1'b0;
  logic          rst_n;
  logic [DW-1:0] probe_i;
  logic          sample_en, arm, abort, rd_en;
  logic [1:0]    trig_mode;
  logic [DW-1:0] trig_mask, trig_value;
  logic [AW-1:0] pre_count;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_last, triggered, done;
  logic [2:0]    state_o;

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] hist[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic          got_last_q[$];

  probe_capture_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .controlCLK(controlCLK), .rst_n(rst_n), .probe_i(probe_i), .sample_en(sample_en),
    .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_mask(trig_mask),
    .trig_value(trig_value), .pre_count(pre_count), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .triggered(triggered), .done(done),
    .state_o(state_o)
  );

  always #5 controlCLK = ~controlCLK;

  always @(negedge controlCLK) begin
    if (rd_valid) begin
      got_q.push_back(rd_data);
      got_last_q.push_back(rd_last);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge controlCLK);
    #1;
  endtask

  task automatic sample(input logic [DW-1:0] v, input logic en);
    probe_i = v;
    sample_en = en;
    tick();
    if (en) hist.push_back(v);
    sample_en = 1'b0;
  endtask

  task automatic configure(input logic [AW-1:0] pre, input logic [1:0] mode,
                           input logic [DW-1:0] mask, input logic [DW-1:0] value);
    pre_count = pre;
    trig_mode = mode;
    trig_mask = mask;
    trig_value = value;
  endtask

  task automatic arm_pulse(input logic [DW-1:0] v, input logic en);
    probe_i = v;
    sample_en = en;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    sample_en = 1'b0;
    hist.delete();
    got_q.delete();
    got_last_q.delete();
    exp_q.delete();
  endtask

  // The capture window is the last DEPTH qualified samples written since arm.
  task automatic load_expected();
    for (int i = hist.size() - DEP; i < hist.size(); i++) exp_q.push_back(hist[i]);
  endtask

  task automatic read_stream(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    probe_i = '0; sample_en = 0; arm = 0; abort = 0; rd_en = 0;
    configure(0, 2'b00, '0, '0);
    repeat (3) tick();
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (triggered !== 1'b0) begin n_fail++; $display("FAIL reset_trig got=%b exp=0", triggered); end
    n_checks++; if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin n_fail++; $display("FAIL reset_rd got=%b%b exp=00", rd_valid, rd_last); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_match();
    configure(4, 2'b00, 8'hFF, 8'h20);
    for (int v = 0; v < 16; v++) sample(8'(v), 1'b1);
    arm_pulse(8'h10, 1'b1);
    for (int v = 8'h11; v < 8'h20; v++) sample(8'(v), 1'b1);
    n_checks++; if (triggered !== 1'b0) begin n_fail++; $display("FAIL match_early got=%b exp=0", triggered); end
    sample(8'h20, 1'b1);
    n_checks++; if (triggered !== 1'b1) begin n_fail++; $display("FAIL match_trig got=%b exp=1", triggered); end
    n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL match_post got=%0d exp=3", state_o); end
    for (int v = 8'h21; v < 8'h2B; v++) sample(8'(v), 1'b1);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL match_done_early got=%b exp=0", done); end
    sample(8'h2B, 1'b1);
    n_checks++; if (done !== 1'b1 || state_o !== 3'd4) begin n_fail++; $display("FAIL match_done got=%b/%0d exp=1/4", done, state_o); end
    load_expected();
    read_stream(DEP + 1);
    n_checks++; if (state_o !== 3'd0 || done !== 1'b0 || triggered !== 1'b0) begin
      n_fail++; $display("FAIL match_end got=%0d/%b/%b exp=0/0/0", state_o, done, triggered); end
    n_checks++; if (got_q.size() !== DEP) begin n_fail++; $display("FAIL match_count got=%0d exp=%0d", got_q.size(), DEP); end
    n_checks++; if (got_q.size() > 4 && got_q[4] !== 8'h20) begin n_fail++; $display("FAIL match_trig_idx got=%h exp=20", got_q[4]); end
    for (int i = 0; i < DEP && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      logic [DW-1:0] g, e;
      logic l;
      g = got_q.pop_front(); l = got_last_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL match_data[%0d] got=%h exp=%h", i, g, e); end
      n_checks++; if (l !== (i == DEP - 1)) begin n_fail++; $display("FAIL match_last[%0d] got=%b exp=%b", i, l, i == DEP - 1); end
    end
  endtask

  task automatic test_clip_qualifier();
    configure(15, 2'b11, 8'h00, 8'h00);
    arm_pulse(8'hEE, 1'b1);
    for (int i = 0; i < 15; i++) begin
      sample(8'(8'h40 + i), 1'b1);
      sample(8'(8'hE0 + i), 1'b0);
    end
    n_checks++; if (done !== 1'b0 || state_o !== 3'd2) begin n_fail++; $display("FAIL clip_wait got=%b/%0d exp=0/2", done, state_o); end
    sample(8'h4F, 1'b1);
    n_checks++; if (done !== 1'b1 || triggered !== 1'b1) begin n_fail++; $display("FAIL clip_done got=%b/%b exp=1/1", done, triggered); end
    load_expected();
    read_stream(DEP + 1);
    n_checks++; if (got_q.size() !== DEP) begin n_fail++; $display("FAIL clip_count got=%0d exp=%0d", got_q.size(), DEP); end
    n_checks++; if (got_q.size() == DEP && got_q[15] !== 8'h4F) begin n_fail++; $display("FAIL clip_trig_idx got=%h exp=4f", got_q[15]); end
    for (int i = 0; i < DEP && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      logic [DW-1:0] g, e;
      logic l;
      g = got_q.pop_front(); l = got_last_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL clip_data[%0d] got=%h exp=%h", i, g, e); end
      n_checks++; if (l !== (i == DEP - 1)) begin n_fail++; $display("FAIL clip_last[%0d] got=%b exp=%b", i, l, i == DEP - 1); end
    end
  endtask

  task automatic test_change();
    configure(4, 2'b01, 8'h07, 8'h00);
    arm_pulse(8'hA0, 1'b1);
    repeat (20) sample(8'hA0, 1'b1);
    sample(8'hA8, 1'b1);
    n_checks++; if (triggered !== 1'b0 || state_o !== 3'd2) begin n_fail++; $display("FAIL change_masked got=%b/%0d exp=0/2", triggered, state_o); end
    sample(8'hA1, 1'b1);
    n_checks++; if (triggered !== 1'b1) begin n_fail++; $display("FAIL change_trig got=%b exp=1", triggered); end
    for (int i = 0; i < 11; i++) sample(8'(8'h60 + i), 1'b1);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL change_done got=%b exp=1", done); end
    load_expected();
    read_stream(DEP + 1);
    n_checks++; if (got_q.size() !== DEP) begin n_fail++; $display("FAIL change_count got=%0d exp=%0d", got_q.size(), DEP); end
    for (int i = 0; i < DEP && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      logic [DW-1:0] g, e;
      logic l;
      g = got_q.pop_front(); l = got_last_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL change_data[%0d] got=%h exp=%h", i, g, e); end
      n_checks++; if (l !== (i == DEP - 1)) begin n_fail++; $display("FAIL change_last[%0d] got=%b exp=%b", i, l, i == DEP - 1); end
    end
  endtask

  task automatic test_match_entry();
    configure(0, 2'b10, 8'hFF, 8'h05);
    arm_pulse(8'h00, 1'b0);
    n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL entry_wait got=%0d exp=2", state_o); end
    sample(8'h05, 1'b1);
    n_checks++; if (triggered !== 1'b0) begin n_fail++; $display("FAIL entry_first got=%b exp=0", triggered); end
    sample(8'h05, 1'b1);
    n_checks++; if (triggered !== 1'b0) begin n_fail++; $display("FAIL entry_second got=%b exp=0", triggered); end
    sample(8'h03, 1'b1);
    sample(8'h05, 1'b1);
    n_checks++; if (triggered !== 1'b1 || state_o !== 3'd3) begin n_fail++; $display("FAIL entry_trig got=%b/%0d exp=1/3", triggered, state_o); end
    for (int i = 0; i < 15; i++) sample(8'(8'h70 + i), 1'b1);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL entry_done got=%b exp=1", done); end
    load_expected();
    read_stream(DEP + 1);
    n_checks++; if (got_q.size() !== DEP) begin n_fail++; $display("FAIL entry_count got=%0d exp=%0d", got_q.size(), DEP); end
    for (int i = 0; i < DEP && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      logic [DW-1:0] g, e;
      logic l;
      g = got_q.pop_front(); l = got_last_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL entry_data[%0d] got=%h exp=%h", i, g, e); end
      n_checks++; if (l !== (i == DEP - 1)) begin n_fail++; $display("FAIL entry_last[%0d] got=%b exp=%b", i, l, i == DEP - 1); end
    end
  endtask

  task automatic test_abort_rearm();
    configure(2, 2'b11, 8'h00, 8'h00);
    arm_pulse(8'h00, 1'b0);
    sample(8'h90, 1'b1);
    sample(8'h91, 1'b1);
    sample(8'h92, 1'b1);
    n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL abort_in_post got=%0d exp=3", state_o); end
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    n_checks++; if (state_o !== 3'd0 || done !== 1'b0 || triggered !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle got=%0d/%b/%b exp=0/0/0", state_o, done, triggered); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++; if (rd_valid !== 1'b0 || state_o !== 3'd0) begin n_fail++; $display("FAIL idle_rd got=%b/%0d exp=0/0", rd_valid, state_o); end
    configure(3, 2'b00, 8'hFF, 8'h55);
    arm_pulse(8'h00, 1'b0);
    for (int v = 8'h50; v < 8'h62; v++) sample(8'(v), 1'b1);
    n_checks++; if (done !== 1'b1 || state_o !== 3'd4) begin n_fail++; $display("FAIL rearm_done got=%b/%0d exp=1/4", done, state_o); end
    load_expected();
  endtask

  task automatic test_read_timing();
    logic [4:0] pat;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rdt_idle got=%b exp=0", rd_valid); end
    rd_en = 1'b1; tick(); pat[0] = rd_valid;
    rd_en = 1'b1; tick(); pat[1] = rd_valid;
    rd_en = 1'b0; tick(); pat[2] = rd_valid;
    rd_en = 1'b1; tick(); pat[3] = rd_valid;
    rd_en = 1'b0;
    n_checks++; if (pat[3:0] !== 4'b1011) begin n_fail++; $display("FAIL rdt_pattern got=%b exp=1011", pat[3:0]); end
    read_stream(DEP - 3 + 1);
    n_checks++; if (state_o !== 3'd0 || done !== 1'b0) begin n_fail++; $display("FAIL rdt_end got=%0d/%b exp=0/0", state_o, done); end
    n_checks++; if (got_q.size() !== DEP) begin n_fail++; $display("FAIL rdt_count got=%0d exp=%0d", got_q.size(), DEP); end
    n_checks++; if (got_q.size() > 3 && got_q[3] !== 8'h55) begin n_fail++; $display("FAIL rdt_trig_idx got=%h exp=55", got_q[3]); end
    for (int i = 0; i < DEP && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      logic [DW-1:0] g, e;
      logic l;
      g = got_q.pop_front(); l = got_last_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL rdt_data[%0d] got=%h exp=%h", i, g, e); end
      n_checks++; if (l !== (i == DEP - 1)) begin n_fail++; $display("FAIL rdt_last[%0d] got=%b exp=%b", i, l, i == DEP - 1); end
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_clip_qualifier();
    test_change();
    test_match_entry();
    test_abort_rearm();
    test_read_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
